mandelbrot_pixel_scheduler: RTL and testbench
=============================================

Name: mandelbrot_pixel_scheduler

Overview:
Upstream and downstream controller for mandelbrot_iterator. It sweeps every pixel of a frame and generates the 4.23 fixed-point Cr/Ci pair for each one. For each pixel it resets and starts the iterator, waits for its done flag, maps the iteration count to an 8-bit colour, and writes the colour to the VGA frame-buffer SRAM port. This is the single sequencer between the HPS start command and the display memory.

Parameters:
H_RES, 640, pixels per row
V_RES, 480, rows per frame
MAX_ITER, 1000, iteration cap; counts >= this are treated as inside the set
CR_START, 27'h7000000, Cr of column 0 (-2.0 in 4.23)
CI_START, 27'h0800000, Ci of row 0 (+1.0 in 4.23)
DCR, 27'h000999A, Cr increment per column (3/640)
DCI, 27'h0008889, Ci decrement per row (2/480)
WATCHDOG, 2047, maximum WAIT cycles before forcing count = MAX_ITER

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
Cr  out  27  signed 4.23 real part to iterator
Ci  out  27  signed 4.23 imaginary part to iterator
iter_rst  out  1  active-high reset pulse to iterator
iter_done  in  1  level; iterator has reached DONE
iter_count  in  10  iterator result, valid while iter_done=1
wr_en  out  1  one-cycle frame-buffer write strobe
wr_addr  out  19  linear address y*H_RES+x
wr_data  out  8  RGB332 colour
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel is written

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE; Cr=CR_START; Ci=CI_START; x=0, y=0; wr_addr=0.
  - wr_en=0, wr_data=0, busy=0, frame_done=0, iter_rst=1.
  - The iterator is held in reset while the scheduler is idle.
- States: IDLE, LOAD, WAIT, WRITE, ADVANCE, FINISH.
- IDLE:
  - iter_rst=1.
  - On start=1, go to LOAD and set busy=1. Cr/Ci/x/y/wr_addr are already at their start values.
  - start in any other state is ignored.
- LOAD: one cycle. iter_rst=1, Cr/Ci stable. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - iter_rst=0. Cr/Ci are held constant for the entire WAIT.
  - iter_done is ignored on the first WAIT cycle (guard against a stale DONE).
  - From the second cycle, when iter_done=1: latch iter_count and go to WRITE.
  - When the watchdog reaches WATCHDOG: latch MAX_ITER and go to WRITE.
- WRITE:
  - wr_en=1 for exactly one cycle.
  - wr_addr = current pixel address; wr_data = colour(latched count).
- ADVANCE:
  - If x < H_RES-1: x+1, Cr+=DCR, wr_addr+1.
  - Otherwise: x=0, Cr=CR_START, y+1, Ci-=DCI, wr_addr+1.
  - If x=H_RES-1 and y=V_RES-1: go to FINISH. Otherwise go to LOAD.
- FINISH:
  - frame_done=1 for one cycle; busy=0.
  - Reload Cr, Ci, x, y and wr_addr to their start values.
  - Go to IDLE.
- Per-pixel latency: LOAD 1 + WAIT (>=2) + WRITE 1 + ADVANCE 1 cycles.
- Arithmetic:
  - Cr/Ci add and subtract use 27-bit two's complement and wrap with no saturation.
  - With the default parameters no wrap occurs.
  - wr_addr is generated by an incrementer only; no multiplier.
- Colour map on the latched count c (10-bit unsigned):
  - c >= MAX_ITER -> 8'h00
  - c >= 256 -> 8'hE0
  - c >= 64 -> 8'hFC
  - c >= 16 -> 8'h1C
  - c >= 4 -> 8'h03
  - else -> 8'h02
- Outputs are registered except iter_rst, busy and frame_done, which are Moore decodes of state.
- A simultaneous start and frame_done cannot occur, because FINISH always passes through IDLE.

Decomposition:
- Shared package mandelbrot_pkg holds:
  - the fixed-point width (27) and fraction bits (23);
  - MAX_ITER and the state encoding;
  - the CR_START/CI_START/DCR/DCI defaults;
  - the frame-buffer address width (19).
- One sub-module, iter_to_color: a combinational count-to-RGB332 lookup, tested standalone.

Test Plan:
- Bench uses H_RES=4, V_RES=3, model iterator returning count=5 after 3 cycles, then a single start pulse:
  - exactly 12 wr_en pulses, wr_addr 0..11 in order, all wr_data=8'h03;
  - one frame_done pulse; busy low afterwards.
- Cr/Ci sweep on the same bench: pixel 0 Cr=27'h7000000; pixel 1 Cr=27'h700999A; pixel 4 Cr=27'h7000000 and Ci=27'h07F7777.
- Colour boundaries via iterator counts 3, 4, 15, 16, 63, 64, 255, 256, 999, 1000:
  - expected colours 02, 03, 03, 1C, 1C, FC, FC, E0, E0, 00.
- Model iterator never raises iter_done: after WATCHDOG WAIT cycles, a write with wr_data=8'h00 occurs and the scan continues.
- Stale-done guard: iter_done held high during LOAD and the first WAIT cycle, then dropped for 3 cycles before reasserting with count=20:
  - the new count is captured, not the stale one;
  - wr_data=8'h1C.
- Reset and start handling:
  - assert rst during WAIT of pixel 5: wr_en=0, busy=0, iter_rst=1 and Cr=27'h7000000 immediately;
  - a following start rescans from wr_addr=0;
  - a start pulse while busy has no effect.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// -----------------------------------------------------------------------------
// mandelbrot_pkg
// Shared definitions for the Mandelbrot pixel scheduler and its colour lookup.
//   - 4.23 signed fixed-point width / fraction bits
//   - iteration counter width and default iteration cap
//   - default complex-plane origin and per-pixel step values
//   - frame-buffer address width
//   - scheduler state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package mandelbrot_pkg;

  // Fixed-point format of Cr/Ci: 27 bits total, 23 fraction bits (4.23).
  localparam int FX_W    = 27;
  localparam int FX_FRAC = 23;

  // Iteration count as delivered by the iterator.
  localparam int CNT_W        = 10;
  localparam int MAX_ITER_DEF = 1000;

  // Frame geometry / frame-buffer defaults.
  localparam int H_RES_DEF    = 640;
  localparam int V_RES_DEF    = 480;
  localparam int ADDR_W       = 19;
  localparam int WATCHDOG_DEF = 2047;

  // Complex-plane sweep defaults (4.23 two's complement).
  localparam logic [FX_W-1:0] CR_START_DEF = 27'h7000000;  // -2.0
  localparam logic [FX_W-1:0] CI_START_DEF = 27'h0800000;  // +1.0
  localparam logic [FX_W-1:0] DCR_DEF      = 27'h000999A;  // 3/640
  localparam logic [FX_W-1:0] DCI_DEF      = 27'h0008889;  // 2/480

  // Scheduler sequencing states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_WRITE   = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/mandelbrot_pixel_scheduler_iter_to_color.sv
// -----------------------------------------------------------------------------
// iter_to_color
// Combinational map from an iteration count to an RGB332 colour.
// Counts at or above MAX_ITER are treated as inside the set (black).
// Ports:
//   i_count  in  CNT_W  iteration count (unsigned)
//   o_color  out 8      RGB332 colour
// -----------------------------------------------------------------------------
module iter_to_color
  import mandelbrot_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic [CNT_W-1:0] i_count,
  output logic [7:0]       o_color
);

  // Compare in 32 bits so a MAX_ITER wider than the count still behaves.
  logic [31:0] w_count32;
  assign w_count32 = 32'(i_count);

  always_comb begin
    o_color = 8'h02;
    if (w_count32 >= 32'(MAX_ITER)) begin
      o_color = 8'h00;
    end else if (w_count32 >= 32'd256) begin
      o_color = 8'hE0;
    end else if (w_count32 >= 32'd64) begin
      o_color = 8'hFC;
    end else if (w_count32 >= 32'd16) begin
      o_color = 8'h1C;
    end else if (w_count32 >= 32'd4) begin
      o_color = 8'h03;
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// -----------------------------------------------------------------------------
// mandelbrot_pixel_scheduler
// Sweeps every pixel of a frame, drives the Cr/Ci pair of each pixel into the
// Mandelbrot iterator, waits for its result, maps the count to a colour and
// writes it to the frame-buffer port at address y*H_RES+x.
//
// Ports:
//   clk         in   1      system clock
//   rst         in   1      asynchronous active-high reset
//   start       in   1      one-cycle pulse, begins a frame when idle
//   Cr, Ci      out  27     4.23 coordinates of the current pixel
//   iter_rst    out  1      iterator reset (high in every state except WAIT)
//   iter_done   in   1      iterator finished (level)
//   iter_count  in   10     iterator result, valid while iter_done=1
//   wr_en       out  1      one-cycle frame-buffer write strobe
//   wr_addr     out  19     linear pixel address
//   wr_data     out  8      RGB332 colour
//   busy        out  1      frame in progress
//   frame_done  out  1      one-cycle pulse after the last pixel is written
//   o_dbg_state out  3      current sequencer state
//
// Handshake: there is no valid/ready pair here. The iterator is "started" by
// releasing iter_rst (entering WAIT) and "completes" by holding iter_done
// high; the scheduler samples iter_done only from the second WAIT cycle on.
// wr_en is a fire-and-forget strobe: the frame buffer accepts every write.
// -----------------------------------------------------------------------------
module mandelbrot_pixel_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int              H_RES    = H_RES_DEF,
  parameter int              V_RES    = V_RES_DEF,
  parameter int              MAX_ITER = MAX_ITER_DEF,
  parameter logic [FX_W-1:0] CR_START = CR_START_DEF,
  parameter logic [FX_W-1:0] CI_START = CI_START_DEF,
  parameter logic [FX_W-1:0] DCR      = DCR_DEF,
  parameter logic [FX_W-1:0] DCI      = DCI_DEF,
  parameter int              WATCHDOG = WATCHDOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [FX_W-1:0]   Cr,
  output logic [FX_W-1:0]   Ci,
  output logic              iter_rst,
  input  logic              iter_done,
  input  logic [CNT_W-1:0]  iter_count,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        o_dbg_state
);

  localparam int X_W  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int WD_W = (WATCHDOG > 1) ? $clog2(WATCHDOG + 1) : 1;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_RES - 1);
  // WAIT lasts at most WATCHDOG cycles; r_wd counts WAIT cycles already spent.
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WATCHDOG - 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_ITER);

  sched_state_t      r_state;
  logic [FX_W-1:0]   r_cr;
  logic [FX_W-1:0]   r_ci;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [WD_W-1:0]   r_wd;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic              w_done_ok;
  logic              w_wd_expire;
  logic [CNT_W-1:0]  w_sel_count;
  logic [7:0]        w_color;

  // r_wd is zero only on the first WAIT cycle, where a DONE left over from
  // the previous pixel may still be visible; ignore it there.
  assign w_done_ok   = (r_wd != '0) && iter_done;
  assign w_wd_expire = (r_wd == WD_LAST);

  // A real result wins over the watchdog if both land on the same cycle.
  assign w_sel_count = w_done_ok ? iter_count : CNT_CAP;

  iter_to_color #(
    .MAX_ITER (MAX_ITER)
  ) u_iter_to_color (
    .i_count (w_sel_count),
    .o_color (w_color)
  );

  // The colour register is loaded on the WAIT->WRITE edge, so it acts as the
  // latched count: wr_data and wr_en are both valid during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cr      <= CR_START;
      r_ci      <= CI_START;
      r_x       <= '0;
      r_y       <= '0;
      r_wd      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (w_done_ok || w_wd_expire) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_color;
            r_state   <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_state <= S_ADVANCE;
        end

        S_ADVANCE: begin
          // Address tracks the raster order, so a plain incrementer suffices.
          r_wr_addr <= r_wr_addr + 1'b1;
          if (r_x != X_LAST) begin
            r_x     <= r_x + 1'b1;
            r_cr    <= r_cr + DCR;
            r_state <= S_LOAD;
          end else begin
            r_x     <= '0;
            r_cr    <= CR_START;
            r_y     <= r_y + 1'b1;
            r_ci    <= r_ci - DCI;
            r_state <= (r_y == Y_LAST) ? S_FINISH : S_LOAD;
          end
        end

        S_FINISH: begin
          r_cr      <= CR_START;
          r_ci      <= CI_START;
          r_x       <= '0;
          r_y       <= '0;
          r_wr_addr <= '0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Cr          = r_cr;
  assign Ci          = r_ci;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign o_dbg_state = r_state;

  // Moore decodes: the iterator only runs in WAIT and is held in reset
  // everywhere else, including IDLE.
  assign iter_rst   = (r_state != S_WAIT);
  assign busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign frame_done = (r_state == S_FINISH);

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
module tb_mandelbrot_pixel_scheduler;
  import mandelbrot_pkg::*;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;
  localparam int WD   = 2047;
  localparam int MAXI = 1000;
  localparam logic [26:0] CR0   = 27'h7000000;
  localparam logic [26:0] CI0   = 27'h0800000;
  localparam logic [26:0] DCR_V = 27'h000999A;
  localparam logic [26:0] DCI_V = 27'h0008889;

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  // ---------------------------------------------------------------- signals
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] cr;
  logic [26:0] ci;
  logic        iter_rst;
  logic        iter_done = 1'b0;
  logic [9:0]  iter_count = 10'd0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic [2:0]  dbg_state;
  logic [9:0]  tv_cnt;
  logic [7:0]  tv_col;

  mandelbrot_pixel_scheduler #(
    .H_RES    (H),
    .V_RES    (V),
    .MAX_ITER (MAXI),
    .CR_START (CR0),
    .CI_START (CI0),
    .DCR      (DCR_V),
    .DCI      (DCI_V),
    .WATCHDOG (WD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .Cr          (cr),
    .Ci          (ci),
    .iter_rst    (iter_rst),
    .iter_done   (iter_done),
    .iter_count  (iter_count),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .o_dbg_state (dbg_state)
  );

  iter_to_color #(.MAX_ITER(MAXI)) u_lut (.i_count(tv_cnt), .o_color(tv_col));

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  // ------------------------------------------------------------ bookkeeping
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-pixel behaviour of the model iterator for the current frame.
  int         cfg_lat  [NPIX];
  int         cfg_mode [NPIX];
  logic [9:0] cfg_cnt  [NPIX];

  // Scoreboard entries: {addr[18:0], data[7:0], Cr[26:0], Ci[26:0]}.
  logic [80:0] exp_q[$];

  logic [26:0] obs_cr  [NPIX];
  logic [26:0] obs_ci  [NPIX];
  int          obs_cyc [NPIX];

  int pix_idx = 0;
  int k       = 0;
  int fd_seen = 0;
  int wr_seen = 0;

  // ------------------------------------------------------ reference model
  function automatic logic [7:0] ref_color(input int c);
    if (c >= MAXI) return 8'h00;
    if (c >= 256)  return 8'hE0;
    if (c >= 64)   return 8'hFC;
    if (c >= 16)   return 8'h1C;
    if (c >= 4)    return 8'h03;
    return 8'h02;
  endfunction

  function automatic logic [26:0] ref_cr(input int p);
    return CR0 + 27'(p % H) * DCR_V;
  endfunction

  function automatic logic [26:0] ref_ci(input int p);
    return CI0 - 27'(p / H) * DCI_V;
  endfunction

  task automatic load_expect();
    for (int p = 0; p < NPIX; p++) begin
      logic [7:0] d;
      if (cfg_mode[p] == M_NEVER)      d = ref_color(MAXI);
      else if (cfg_mode[p] == M_STALE) d = ref_color(20);
      else                             d = ref_color(int'(cfg_cnt[p]));
      exp_q.push_back({19'(p), d, ref_cr(p), ref_ci(p)});
    end
  endtask

  task automatic on_write();
    logic [80:0] e;
    wr_seen++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
    end else begin
      e = exp_q.pop_front();
      check("write_addr_data_cr_ci", {wr_addr, wr_data, cr, ci}, e);
    end
    if (pix_idx < NPIX) begin
      obs_cr[pix_idx]  = cr;
      obs_ci[pix_idx]  = ci;
      obs_cyc[pix_idx] = cyc;
    end
    pix_idx++;
  endtask

  // Monitor plus model iterator, evaluated on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      k          = 0;
      pix_idx    = 0;
      iter_done  = 1'b0;
      iter_count = 10'd0;
    end else begin
      if (wr_en) on_write();
      if (frame_done) begin
        fd_seen++;
        pix_idx = 0;
      end
      if (iter_rst) begin
        k = 0;
        if (pix_idx < NPIX && cfg_mode[pix_idx] == M_STALE) begin
          iter_done  = 1'b1;
          iter_count = 10'd1000;
        end else begin
          iter_done  = 1'b0;
          iter_count = 10'd0;
        end
      end else begin
        k++;
        if (pix_idx < NPIX) begin
          check("wait_cr_hold", 81'(cr), 81'(ref_cr(pix_idx)));
          check("wait_ci_hold", 81'(ci), 81'(ref_ci(pix_idx)));
          case (cfg_mode[pix_idx])
            M_NEVER: begin
              iter_done  = 1'b0;
              iter_count = 10'd0;
            end
            M_STALE: begin
              if (k == 1) begin
                iter_done  = 1'b1;
                iter_count = 10'd1000;
              end else if (k <= 4) begin
                iter_done  = 1'b0;
                iter_count = 10'd0;
              end else begin
                iter_done  = 1'b1;
                iter_count = 10'd20;
              end
            end
            default: begin
              iter_done  = (k >= cfg_lat[pix_idx]);
              iter_count = iter_done ? cfg_cnt[pix_idx] : 10'd0;
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit extra_start, input int budget);
    int n;
    int fd_base;
    int wr_base;
    fd_base = fd_seen;
    wr_base = wr_seen;
    load_expect();
    pulse_start();
    if (extra_start) begin
      repeat (3) @(negedge clk);
      check({tag, "_busy_mid"}, 81'(busy), 81'(1));
      pulse_start();
    end
    n = 0;
    while (fd_seen == fd_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_seen == fd_base) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_frame_done_timeout: no frame_done after %0d cycles, expected one", tag, budget);
    end
    repeat (5) @(negedge clk);
    check({tag, "_write_count"}, 81'(wr_seen - wr_base), 81'(NPIX));
    check({tag, "_frame_done_count"}, 81'(fd_seen - fd_base), 81'(1));
    check({tag, "_queue_left"}, 81'(exp_q.size()), 81'(0));
    check({tag, "_busy_after"}, 81'(busy), 81'(0));
    check({tag, "_iter_rst_idle"}, 81'(iter_rst), 81'(1));
    exp_q.delete();
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct packed {
    logic [9:0] cnt;
    logic [7:0] col;
  } vec_t;

  vec_t vt [10];

  // ---------------------------------------------------------------- test
  initial begin
    int n;
    int gap;
    int wr_hold;

    vt[0] = '{cnt: 10'd3,    col: 8'h02};
    vt[1] = '{cnt: 10'd4,    col: 8'h03};
    vt[2] = '{cnt: 10'd15,   col: 8'h03};
    vt[3] = '{cnt: 10'd16,   col: 8'h1C};
    vt[4] = '{cnt: 10'd63,   col: 8'h1C};
    vt[5] = '{cnt: 10'd64,   col: 8'hFC};
    vt[6] = '{cnt: 10'd255,  col: 8'hFC};
    vt[7] = '{cnt: 10'd256,  col: 8'hE0};
    vt[8] = '{cnt: 10'd999,  col: 8'hE0};
    vt[9] = '{cnt: 10'd1000, col: 8'h00};

    for (int p = 0; p < NPIX; p++) begin
      cfg_lat[p]  = 3;
      cfg_mode[p] = M_NORMAL;
      cfg_cnt[p]  = 10'd5;
    end

    rst    = 1'b1;
    start  = 1'b0;
    tv_cnt = 10'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cr", 81'(cr), 81'(CR0));
    check("rst_ci", 81'(ci), 81'(CI0));
    check("rst_wr_addr", 81'(wr_addr), 81'(0));
    check("rst_wr_en", 81'(wr_en), 81'(0));
    check("rst_wr_data", 81'(wr_data), 81'(0));
    check("rst_busy", 81'(busy), 81'(0));
    check("rst_frame_done", 81'(frame_done), 81'(0));
    check("rst_iter_rst", 81'(iter_rst), 81'(1));
    check("rst_state", 81'(dbg_state), 81'(S_IDLE));
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Colour lookup standalone, table driven.
    for (int i = 0; i < 10; i++) begin
      tv_cnt = vt[i].cnt;
      #1;
      check("color_lut", 81'(tv_col), 81'(vt[i].col));
    end

    // Frame A: count 5 after 3 cycles everywhere, start while busy ignored.
    run_frame("frame_a", 1'b1, 2000);
    check("sweep_p0_cr", 81'(obs_cr[0]), 81'(27'h7000000));
    check("sweep_p1_cr", 81'(obs_cr[1]), 81'(27'h700999A));
    check("sweep_p4_cr", 81'(obs_cr[4]), 81'(27'h7000000));
    check("sweep_p4_ci", 81'(obs_ci[4]), 81'(27'h07F7777));
    wr_hold = wr_seen;
    repeat (20) @(negedge clk);
    check("frame_a_no_restart_writes", 81'(wr_seen - wr_hold), 81'(0));
    check("frame_a_no_restart_busy", 81'(busy), 81'(0));

    // Frame B: colour boundaries, watchdog pixel, stale-done pixel.
    for (int p = 0; p < 10; p++) begin
      cfg_mode[p] = M_NORMAL;
      cfg_cnt[p]  = vt[p].cnt;
      cfg_lat[p]  = $urandom_range(1, 6);
    end
    cfg_mode[10] = M_NEVER;
    cfg_mode[11] = M_STALE;
    run_frame("frame_b", 1'b0, 20000);
    gap = obs_cyc[10] - obs_cyc[9];
    n_cmp++;
    if (gap < WD + 2 || gap > WD + 4) begin
      n_bad++;
      $display("FAIL watchdog_gap: got %0d cycles between writes, expected %0d..%0d", gap, WD + 2, WD + 4);
    end

    // Frame C: random counts, reset asserted during WAIT of pixel 5.
    for (int p = 0; p < NPIX; p++) begin
      cfg_mode[p] = M_NORMAL;
      cfg_cnt[p]  = 10'($urandom_range(0, 1023));
      cfg_lat[p]  = $urandom_range(1, 8);
    end
    load_expect();
    pulse_start();
    n = 0;
    while (!(pix_idx == 5 && iter_rst == 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_pixel5_wait", 81'(pix_idx == 5 && iter_rst == 1'b0), 81'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_wr_en", 81'(wr_en), 81'(0));
    check("midrst_busy", 81'(busy), 81'(0));
    check("midrst_iter_rst", 81'(iter_rst), 81'(1));
    check("midrst_cr", 81'(cr), 81'(CR0));
    check("midrst_ci", 81'(ci), 81'(CI0));
    check("midrst_wr_addr", 81'(wr_addr), 81'(0));
    check("midrst_wr_data", 81'(wr_data), 81'(0));
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Frame D: fresh random frame must rescan from address 0.
    for (int p = 0; p < NPIX; p++) begin
      cfg_cnt[p] = 10'($urandom_range(0, 1023));
      cfg_lat[p] = $urandom_range(1, 8);
    end
    run_frame("frame_d", 1'b0, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
